cluster_unpacker: RTL and testbench

Inverse of the S-bit cluster packer. Takes one bunch crossing's 8 x 14-bit clusters ({cnt[2:0], adr[10:0]}) and expands them back into the full 1536-bit S-bit map. The map is presented as 24 x 64-bit VFAT words. Used on the receive side for data-quality monitoring and for packer loopback checking.

---
 rtl/cluster_unpacker_if.sv | 35 +++
 rtl/cluster_unpacker.sv | 176 +++++++++++++++++
 tb/tb_cluster_unpacker.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cluster_unpacker_if.sv
// Receive-side cluster bus: one bx of eight clusters in, the rebuilt 24 x 64 S-bit map out.
interface cluster_unpacker_if #(
  parameter int MXSBITS    = 64,
  parameter int MXCLSTBITS = 14
);
  logic                  clusters_valid;
  logic [MXCLSTBITS-1:0] cluster0, cluster1, cluster2, cluster3;
  logic [MXCLSTBITS-1:0] cluster4, cluster5, cluster6, cluster7;
  logic                  busy;
  logic                  sbits_valid;
  logic [MXSBITS-1:0]    vfat0,  vfat1,  vfat2,  vfat3,  vfat4,  vfat5,  vfat6,  vfat7;
  logic [MXSBITS-1:0]    vfat8,  vfat9,  vfat10, vfat11, vfat12, vfat13, vfat14, vfat15;
  logic [MXSBITS-1:0]    vfat16, vfat17, vfat18, vfat19, vfat20, vfat21, vfat22, vfat23;
  logic [3:0]            n_clusters;
  logic                  overflow;
  logic [7:0]            drop_count;

  modport master (
    output clusters_valid,
    output cluster0, cluster1, cluster2, cluster3, cluster4, cluster5, cluster6, cluster7,
    input  busy, sbits_valid, n_clusters, overflow, drop_count,
    input  vfat0,  vfat1,  vfat2,  vfat3,  vfat4,  vfat5,  vfat6,  vfat7,
    input  vfat8,  vfat9,  vfat10, vfat11, vfat12, vfat13, vfat14, vfat15,
    input  vfat16, vfat17, vfat18, vfat19, vfat20, vfat21, vfat22, vfat23
  );

  modport slave (
    input  clusters_valid,
    input  cluster0, cluster1, cluster2, cluster3, cluster4, cluster5, cluster6, cluster7,
    output busy, sbits_valid, n_clusters, overflow, drop_count,
    output vfat0,  vfat1,  vfat2,  vfat3,  vfat4,  vfat5,  vfat6,  vfat7,
    output vfat8,  vfat9,  vfat10, vfat11, vfat12, vfat13, vfat14, vfat15,
    output vfat16, vfat17, vfat18, vfat19, vfat20, vfat21, vfat22, vfat23
  );
endinterface

// File: rtl/cluster_unpacker.sv
// Expands one bx of eight {cnt, adr} S-bit clusters back into the 1536-bit chamber map,
// one cluster per cycle, and presents it as 24 registered VFAT words.
module cluster_unpacker #(
  parameter int MXSBITS    = 64,
  parameter int MXKEYS     = 3 * MXSBITS,
  parameter int MXPADS     = 24 * MXSBITS,
  parameter int MXROWS     = 8,
  parameter int MXCNTBITS  = 3,
  parameter int MXADRBITS  = 11,
  parameter int MXCLSTBITS = 14,
  parameter int MXCLUSTERS = 8
) (
  input  logic               clock4x,
  input  logic               global_reset,
  cluster_unpacker_if.slave  bus
);

  localparam int IDX_W = $clog2(MXCLUSTERS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MXCLUSTERS - 1);

  typedef enum logic [1:0] {IDLE, EXPAND, PRESENT} state_t;

  state_t                  state_q, state_d;
  logic [MXCLSTBITS-1:0]   clst_p0 [MXCLUSTERS];
  logic [IDX_W-1:0]        idx_q;
  logic [MXPADS-1:0]       acc_p1;
  logic [3:0]              n_acc_p1;
  logic [MXPADS-1:0]       sbits_p2;
  logic [3:0]              n_clusters_p2;
  logic                    vld_p2;
  logic                    overflow_q;
  logic [7:0]              drop_count_q;
  logic [MXCLSTBITS-1:0]   cur_clst;

  function automatic logic cluster_valid(input logic [MXCLSTBITS-1:0] c);
    return c[MXADRBITS-1:0] < MXADRBITS'(MXPADS);
  endfunction

  // Strip keys past the end of the partition are clipped, so a cluster never spills into the next row.
  function automatic logic [MXPADS-1:0] cluster_mask(input logic [MXCLSTBITS-1:0] c);
    logic [MXPADS-1:0]    m;
    logic [MXADRBITS-1:0] adr;
    logic [MXCNTBITS-1:0] cnt;
    logic [2:0]           row;
    logic [7:0]           key;
    logic [7:0]           s;
    logic [4:0]           vf;
    m   = '0;
    adr = c[MXADRBITS-1:0];
    cnt = c[MXCLSTBITS-1 -: MXCNTBITS];
    row = '0;
    key = '0;
    s   = '0;
    vf  = '0;
    if (adr < MXADRBITS'(MXPADS)) begin
      row = 3'(adr / MXADRBITS'(MXKEYS));
      key = 8'(adr - MXADRBITS'(row) * MXADRBITS'(MXKEYS));
      for (int i = 0; i < (1 << MXCNTBITS); i++) begin
        s = key + 8'(i);
        if (i <= int'(cnt) && s < 8'(MXKEYS)) begin
          vf = 5'(row) + 5'(MXROWS) * 5'(s[7:6]);
          m[int'(vf) * MXSBITS + int'(s[5:0])] = 1'b1;
        end
      end
    end
    return m;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] d);
    return (d == 8'hFF) ? d : d + 8'd1;
  endfunction

  assign cur_clst = clst_p0[idx_q];

  always_ff @(posedge clock4x) begin
    if (global_reset) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.clusters_valid) state_d = EXPAND;
      EXPAND:  if (idx_q == IDX_LAST) state_d = PRESENT;
      PRESENT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: capture the bx so the upstream bus is free for the next crossing.
  always_ff @(posedge clock4x) begin
    if (state_q == IDLE && bus.clusters_valid) begin
      clst_p0[0] <= bus.cluster0;
      clst_p0[1] <= bus.cluster1;
      clst_p0[2] <= bus.cluster2;
      clst_p0[3] <= bus.cluster3;
      clst_p0[4] <= bus.cluster4;
      clst_p0[5] <= bus.cluster5;
      clst_p0[6] <= bus.cluster6;
      clst_p0[7] <= bus.cluster7;
    end
  end

  // Stage p1: accumulate one cluster per cycle; stage p2: present the finished map.
  always_ff @(posedge clock4x) begin
    if (global_reset) begin
      idx_q         <= '0;
      acc_p1        <= '0;
      n_acc_p1      <= '0;
      sbits_p2      <= '0;
      n_clusters_p2 <= '0;
      vld_p2        <= 1'b0;
      overflow_q    <= 1'b0;
      drop_count_q  <= '0;
    end else begin
      vld_p2     <= 1'b0;
      overflow_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.clusters_valid) begin
            idx_q    <= '0;
            acc_p1   <= '0;
            n_acc_p1 <= '0;
          end
        end
        EXPAND: begin
          acc_p1   <= acc_p1 | cluster_mask(cur_clst);
          n_acc_p1 <= n_acc_p1 + {3'b000, cluster_valid(cur_clst)};
          idx_q    <= idx_q + 1'b1;
        end
        PRESENT: begin
          sbits_p2      <= acc_p1;
          n_clusters_p2 <= n_acc_p1;
          vld_p2        <= 1'b1;
        end
        default: ;
      endcase
      if (bus.clusters_valid && state_q != IDLE) begin
        overflow_q   <= 1'b1;
        drop_count_q <= sat_inc(drop_count_q);
      end
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.sbits_valid = vld_p2;
  assign bus.n_clusters  = n_clusters_p2;
  assign bus.overflow    = overflow_q;
  assign bus.drop_count  = drop_count_q;

  assign bus.vfat0  = sbits_p2[ 0*MXSBITS +: MXSBITS];
  assign bus.vfat1  = sbits_p2[ 1*MXSBITS +: MXSBITS];
  assign bus.vfat2  = sbits_p2[ 2*MXSBITS +: MXSBITS];
  assign bus.vfat3  = sbits_p2[ 3*MXSBITS +: MXSBITS];
  assign bus.vfat4  = sbits_p2[ 4*MXSBITS +: MXSBITS];
  assign bus.vfat5  = sbits_p2[ 5*MXSBITS +: MXSBITS];
  assign bus.vfat6  = sbits_p2[ 6*MXSBITS +: MXSBITS];
  assign bus.vfat7  = sbits_p2[ 7*MXSBITS +: MXSBITS];
  assign bus.vfat8  = sbits_p2[ 8*MXSBITS +: MXSBITS];
  assign bus.vfat9  = sbits_p2[ 9*MXSBITS +: MXSBITS];
  assign bus.vfat10 = sbits_p2[10*MXSBITS +: MXSBITS];
  assign bus.vfat11 = sbits_p2[11*MXSBITS +: MXSBITS];
  assign bus.vfat12 = sbits_p2[12*MXSBITS +: MXSBITS];
  assign bus.vfat13 = sbits_p2[13*MXSBITS +: MXSBITS];
  assign bus.vfat14 = sbits_p2[14*MXSBITS +: MXSBITS];
  assign bus.vfat15 = sbits_p2[15*MXSBITS +: MXSBITS];
  assign bus.vfat16 = sbits_p2[16*MXSBITS +: MXSBITS];
  assign bus.vfat17 = sbits_p2[17*MXSBITS +: MXSBITS];
  assign bus.vfat18 = sbits_p2[18*MXSBITS +: MXSBITS];
  assign bus.vfat19 = sbits_p2[19*MXSBITS +: MXSBITS];
  assign bus.vfat20 = sbits_p2[20*MXSBITS +: MXSBITS];
  assign bus.vfat21 = sbits_p2[21*MXSBITS +: MXSBITS];
  assign bus.vfat22 = sbits_p2[22*MXSBITS +: MXSBITS];
  assign bus.vfat23 = sbits_p2[23*MXSBITS +: MXSBITS];

endmodule

// File: tb/tb_cluster_unpacker.sv
// Bench for cluster_unpacker: directed corner cases plus random bx and packer loopback
// against a strip-level reference model.
module tb_cluster_unpacker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cluster_unpacker_if bus ();
  cluster_unpacker dut (.clock4x(clk), .global_reset(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  localparam logic [13:0] EMPTY = 14'h7FF;

  logic [1535:0] got_map;
  assign got_map = {bus.vfat23, bus.vfat22, bus.vfat21, bus.vfat20, bus.vfat19, bus.vfat18,
                    bus.vfat17, bus.vfat16, bus.vfat15, bus.vfat14, bus.vfat13, bus.vfat12,
                    bus.vfat11, bus.vfat10, bus.vfat9,  bus.vfat8,  bus.vfat7,  bus.vfat6,
                    bus.vfat5,  bus.vfat4,  bus.vfat3,  bus.vfat2,  bus.vfat1,  bus.vfat0};

  // ---------------- reference model ----------------
  function automatic int strip_bit(input int row, input int key);
    return (row + 8 * (key / 64)) * 64 + (key % 64);
  endfunction

  function automatic logic [13:0] mk(input int cnt, input int adr);
    logic [13:0] c;
    c = {cnt[2:0], adr[10:0]};
    return c;
  endfunction

  function automatic logic [1535:0] ref_map(input logic [111:0] cl);
    logic [1535:0] m;
    int a, c, row, key;
    m = '0;
    for (int n = 0; n < 8; n++) begin
      c = int'(cl[n*14+11 +: 3]);
      a = int'(cl[n*14 +: 11]);
      if (a < 1536) begin
        row = a / 192;
        key = a % 192;
        for (int j = 0; j <= c; j++)
          if (key + j < 192) m[strip_bit(row, key + j)] = 1'b1;
      end
    end
    return m;
  endfunction

  function automatic int ref_count(input logic [111:0] cl);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) if (int'(cl[i*14 +: 11]) < 1536) n++;
    return n;
  endfunction

  function automatic logic [13:0] rand_cluster();
    int a, c;
    c = int'($urandom_range(0, 7));
    if ($urandom_range(0, 3) == 0) a = 1536 + int'($urandom_range(0, 511));
    else                           a = int'($urandom_range(0, 1535));
    return mk(c, a);
  endfunction

  function automatic int diff_vfat(input logic [1535:0] a, input logic [1535:0] b);
    for (int v = 0; v < 24; v++) if (a[v*64 +: 64] !== b[v*64 +: 64]) return v;
    return 0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_clusters(input logic [111:0] cl);
    bus.cluster0 = cl[ 0 +: 14]; bus.cluster1 = cl[14 +: 14];
    bus.cluster2 = cl[28 +: 14]; bus.cluster3 = cl[42 +: 14];
    bus.cluster4 = cl[56 +: 14]; bus.cluster5 = cl[70 +: 14];
    bus.cluster6 = cl[84 +: 14]; bus.cluster7 = cl[98 +: 14];
  endtask

  // Presents one strobe; returns just after the edge that sampled it.
  task automatic send(input logic [111:0] cl);
    set_clusters(cl);
    bus.clusters_valid = 1'b1;
    @(negedge clk);
    bus.clusters_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (bus.sbits_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [111:0] all_empty();
    logic [111:0] cl;
    for (int i = 0; i < 8; i++) cl[i*14 +: 14] = EMPTY;
    return cl;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.clusters_valid = 1'b0;
    set_clusters(all_empty());
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.sbits_valid !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b sbits_valid=%b overflow=%b, expected 0 0 0",
               bus.busy, bus.sbits_valid, bus.overflow);
    end
    checks++;
    if (bus.n_clusters !== 4'd0 || bus.drop_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_counts: n_clusters=%0d drop_count=%0d, expected 0 0",
               bus.n_clusters, bus.drop_count);
    end
    checks++;
    if (got_map !== '0) begin
      errors++;
      $display("FAIL reset_map: vfat%0d=%h, expected 0", diff_vfat(got_map, '0),
               got_map[diff_vfat(got_map, '0)*64 +: 64]);
    end
  endtask

  task automatic test_single();
    logic [111:0] cl;
    logic [1535:0] exp;
    int lat;
    cl = all_empty();
    cl[13:0] = mk(0, 0);
    exp = '0;
    exp[0] = 1'b1;
    send(cl);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL single_busy: busy=%b, expected 1", bus.busy);
    end
    wait_valid(lat);
    checks++;
    if (lat !== 9) begin
      errors++; $display("FAIL single_latency: sbits_valid after %0d edges, expected 9", lat);
    end
    checks++;
    if (got_map !== exp) begin
      errors++;
      $display("FAIL single_map: vfat%0d=%h, expected %h", diff_vfat(got_map, exp),
               got_map[diff_vfat(got_map, exp)*64 +: 64], exp[diff_vfat(got_map, exp)*64 +: 64]);
    end
    checks++;
    if (bus.n_clusters !== 4'd1) begin
      errors++; $display("FAIL single_count: n_clusters=%0d, expected 1", bus.n_clusters);
    end
    @(negedge clk);
    checks++;
    if (bus.sbits_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse: sbits_valid=%b busy=%b one cycle later, expected 0 0",
               bus.sbits_valid, bus.busy);
    end
    checks++;
    if (got_map !== exp) begin
      errors++; $display("FAIL single_hold: vfat0=%h, expected %h", bus.vfat0, exp[63:0]);
    end
  endtask

  task automatic test_wide_and_clip();
    logic [111:0] cl;
    int lat;
    cl = all_empty();
    cl[13:0] = mk(7, 250);
    send(cl);
    wait_valid(lat);
    checks++;
    if (lat !== 9 || bus.vfat1[63:58] !== 6'h3F || bus.vfat9[1:0] !== 2'b11) begin
      errors++;
      $display("FAIL wide_cross: lat=%0d vfat1[63:58]=%h vfat9[1:0]=%b, expected 9 3f 11",
               lat, bus.vfat1[63:58], bus.vfat9[1:0]);
    end
    checks++;
    if (got_map !== ref_map(cl) || bus.n_clusters !== 4'd1) begin
      errors++;
      $display("FAIL wide_map: vfat%0d=%h n=%0d, expected %h n=1", diff_vfat(got_map, ref_map(cl)),
               got_map[diff_vfat(got_map, ref_map(cl))*64 +: 64], bus.n_clusters,
               ref_map(cl)[diff_vfat(got_map, ref_map(cl))*64 +: 64]);
    end
    cl[13:0] = mk(7, 191);
    send(cl);
    wait_valid(lat);
    checks++;
    if (lat !== 9 || bus.vfat16 !== 64'h8000_0000_0000_0000 || bus.vfat1[0] !== 1'b0) begin
      errors++;
      $display("FAIL clip_edge: lat=%0d vfat16=%h vfat1[0]=%b, expected 9 8000000000000000 0",
               lat, bus.vfat16, bus.vfat1[0]);
    end
    checks++;
    if (got_map !== ref_map(cl)) begin
      errors++;
      $display("FAIL clip_map: vfat%0d=%h, expected %h", diff_vfat(got_map, ref_map(cl)),
               got_map[diff_vfat(got_map, ref_map(cl))*64 +: 64],
               ref_map(cl)[diff_vfat(got_map, ref_map(cl))*64 +: 64]);
    end
  endtask

  task automatic test_eight_and_invalid();
    logic [111:0] cl;
    int lat;
    cl[13:0]  = mk(3, 1200);
    cl[27:14] = mk(1, 1202);
    for (int i = 2; i < 8; i++) cl[i*14 +: 14] = mk(int'($urandom_range(0, 7)), 192 * (i - 2) + 10 * i);
    send(cl);
    wait_valid(lat);
    checks++;
    if (lat !== 9 || bus.vfat6[51:48] !== 4'hF || bus.n_clusters !== 4'd8) begin
      errors++;
      $display("FAIL eight_overlap: lat=%0d vfat6[51:48]=%h n=%0d, expected 9 f 8",
               lat, bus.vfat6[51:48], bus.n_clusters);
    end
    checks++;
    if (got_map !== ref_map(cl)) begin
      errors++;
      $display("FAIL eight_map: vfat%0d=%h, expected %h", diff_vfat(got_map, ref_map(cl)),
               got_map[diff_vfat(got_map, ref_map(cl))*64 +: 64],
               ref_map(cl)[diff_vfat(got_map, ref_map(cl))*64 +: 64]);
    end
    for (int i = 0; i < 8; i++) cl[i*14 +: 14] = mk(int'($urandom_range(0, 7)), 1536 + int'($urandom_range(0, 511)));
    send(cl);
    wait_valid(lat);
    checks++;
    if (lat !== 9 || got_map !== '0 || bus.n_clusters !== 4'd0) begin
      errors++;
      $display("FAIL all_invalid: lat=%0d vfat%0d=%h n=%0d, expected 9 0 0", lat,
               diff_vfat(got_map, '0), got_map[diff_vfat(got_map, '0)*64 +: 64], bus.n_clusters);
    end
  endtask

  task automatic test_random();
    logic [111:0] cl;
    int lat;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 8; i++) cl[i*14 +: 14] = rand_cluster();
      send(cl);
      wait_valid(lat);
      checks++;
      if (lat !== 9 || got_map !== ref_map(cl) || int'(bus.n_clusters) !== ref_count(cl)) begin
        errors++;
        $display("FAIL random_bx%0d: lat=%0d vfat%0d=%h n=%0d, expected 9 %h n=%0d", t, lat,
                 diff_vfat(got_map, ref_map(cl)), got_map[diff_vfat(got_map, ref_map(cl))*64 +: 64],
                 bus.n_clusters, ref_map(cl)[diff_vfat(got_map, ref_map(cl))*64 +: 64], ref_count(cl));
      end
    end
  endtask

  task automatic test_loopback();
    logic [1535:0] m;
    logic [111:0] cl;
    int row, start, len, n, k, lat;
    for (int t = 0; t < 100; t++) begin
      m = '0;
      for (int r = 0; r < int'($urandom_range(0, 4)); r++) begin
        row   = int'($urandom_range(0, 7));
        start = int'($urandom_range(0, 191));
        len   = int'($urandom_range(1, 12));
        for (int j = 0; j < len; j++) if (start + j < 192) m[strip_bit(row, start + j)] = 1'b1;
      end
      // Reference packer: runs of set strips, split into chunks of at most eight.
      cl = all_empty();
      n  = 0;
      for (int r = 0; r < 8; r++) begin
        k = 0;
        while (k < 192) begin
          if (m[strip_bit(r, k)]) begin
            len = 0;
            while (k + len < 192 && len < 8 && m[strip_bit(r, k + len)]) len++;
            if (n < 8) cl[n*14 +: 14] = mk(len - 1, r * 192 + k);
            n++;
            k += len;
          end else begin
            k++;
          end
        end
      end
      send(cl);
      wait_valid(lat);
      checks++;
      if (lat !== 9 || got_map !== m || int'(bus.n_clusters) !== n) begin
        errors++;
        $display("FAIL loopback%0d: lat=%0d vfat%0d=%h n=%0d, expected 9 %h n=%0d", t, lat,
                 diff_vfat(got_map, m), got_map[diff_vfat(got_map, m)*64 +: 64], bus.n_clusters,
                 m[diff_vfat(got_map, m)*64 +: 64], n);
      end
    end
  endtask

  task automatic test_drop();
    logic [111:0] cl1, cl2;
    int lat;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cl1[i*14 +: 14] = rand_cluster();
      cl2[i*14 +: 14] = mk(7, 1345 + 20 * i);
    end
    cl1[13:0] = mk(2, 100);
    send(cl1);
    repeat (3) @(negedge clk);
    set_clusters(cl2);
    bus.clusters_valid = 1'b1;
    @(negedge clk);
    bus.clusters_valid = 1'b0;
    checks++;
    if (bus.overflow !== 1'b1 || bus.drop_count !== 8'd1) begin
      errors++;
      $display("FAIL drop_pulse: overflow=%b drop_count=%0d, expected 1 1", bus.overflow, bus.drop_count);
    end
    @(negedge clk);
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++; $display("FAIL drop_pulse_width: overflow=%b, expected 0", bus.overflow);
    end
    wait_valid(lat);
    checks++;
    if (lat !== 4 || got_map !== ref_map(cl1) || int'(bus.n_clusters) !== ref_count(cl1)) begin
      errors++;
      $display("FAIL drop_first_bx: lat=%0d vfat%0d=%h n=%0d, expected 4 %h n=%0d", lat,
               diff_vfat(got_map, ref_map(cl1)), got_map[diff_vfat(got_map, ref_map(cl1))*64 +: 64],
               bus.n_clusters, ref_map(cl1)[diff_vfat(got_map, ref_map(cl1))*64 +: 64], ref_count(cl1));
    end
    wait_valid(lat);
    checks++;
    if (lat !== -1) begin
      errors++; $display("FAIL drop_extra_valid: sbits_valid after %0d edges, expected none", lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [111:0] cl1, cl2, cl3;
    int lat;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cl1[i*14 +: 14] = rand_cluster();
      cl2[i*14 +: 14] = rand_cluster();
      cl3[i*14 +: 14] = rand_cluster();
    end
    send(cl1);
    repeat (8) @(negedge clk);
    set_clusters(cl2);
    bus.clusters_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.sbits_valid !== 1'b1 || got_map !== ref_map(cl1) || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL b2b_present_drop: sbits_valid=%b overflow=%b vfat%0d=%h, expected 1 1 %h",
               bus.sbits_valid, bus.overflow, diff_vfat(got_map, ref_map(cl1)),
               got_map[diff_vfat(got_map, ref_map(cl1))*64 +: 64],
               ref_map(cl1)[diff_vfat(got_map, ref_map(cl1))*64 +: 64]);
    end
    set_clusters(cl3);
    @(negedge clk);
    bus.clusters_valid = 1'b0;
    checks++;
    if (bus.overflow !== 1'b0 || bus.busy !== 1'b1 || bus.drop_count !== 8'd1) begin
      errors++;
      $display("FAIL b2b_accept: overflow=%b busy=%b drop_count=%0d, expected 0 1 1",
               bus.overflow, bus.busy, bus.drop_count);
    end
    wait_valid(lat);
    checks++;
    if (lat !== 9 || got_map !== ref_map(cl3) || int'(bus.n_clusters) !== ref_count(cl3)) begin
      errors++;
      $display("FAIL b2b_second_bx: lat=%0d vfat%0d=%h n=%0d, expected 9 %h n=%0d", lat,
               diff_vfat(got_map, ref_map(cl3)), got_map[diff_vfat(got_map, ref_map(cl3))*64 +: 64],
               bus.n_clusters, ref_map(cl3)[diff_vfat(got_map, ref_map(cl3))*64 +: 64], ref_count(cl3));
    end
  endtask

  task automatic test_saturate();
    int waited;
    set_clusters(all_empty());
    bus.clusters_valid = 1'b1;
    repeat (400) @(negedge clk);
    bus.clusters_valid = 1'b0;
    checks++;
    if (bus.drop_count !== 8'd255) begin
      errors++; $display("FAIL drop_saturate: drop_count=%0d, expected 255", bus.drop_count);
    end
    waited = 0;
    while (bus.busy === 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL saturate_drain: busy=%b after %0d cycles, expected 0", bus.busy, waited);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [111:0] cl1, cl2;
    int lat;
    cl1 = all_empty();
    cl1[13:0] = mk(5, 700);
    send(cl1);
    wait_valid(lat);
    for (int i = 0; i < 8; i++) cl2[i*14 +: 14] = rand_cluster();
    send(cl2);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.sbits_valid !== 1'b0 || got_map !== '0 ||
        bus.n_clusters !== 4'd0 || bus.drop_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b valid=%b vfat%0d=%h n=%0d drops=%0d, expected 0 0 0 0 0",
               bus.busy, bus.sbits_valid, diff_vfat(got_map, '0),
               got_map[diff_vfat(got_map, '0)*64 +: 64], bus.n_clusters, bus.drop_count);
    end
    @(negedge clk);
    cl1 = all_empty();
    cl1[27:14] = mk(4, 1000);
    send(cl1);
    wait_valid(lat);
    checks++;
    if (lat !== 9 || got_map !== ref_map(cl1) || bus.n_clusters !== 4'd1) begin
      errors++;
      $display("FAIL reset_mid_recover: lat=%0d vfat%0d=%h n=%0d, expected 9 %h n=1", lat,
               diff_vfat(got_map, ref_map(cl1)), got_map[diff_vfat(got_map, ref_map(cl1))*64 +: 64],
               bus.n_clusters, ref_map(cl1)[diff_vfat(got_map, ref_map(cl1))*64 +: 64]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wide_and_clip();
    test_eight_and_invalid();
    test_random();
    test_loopback();
    test_drop();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
